// File: rtl/seg_display_driver_if.sv
// Bundles the load/convert handshake and the scan/display signals of seg_display_driver.
// The master side loads values and scans digits; the slave side is the driver.
interface seg_display_driver_if #(
    parameter int VAL_W = 14
);
    logic [VAL_W-1:0] value;
    logic             load;
    logic [1:0]       digit_sel;
    logic             blank_lead;
    logic [3:0]       anode;
    logic [6:0]       segment;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output value, load, digit_sel, blank_lead,
        input  anode, segment, busy, done, overflow
    );

    modport slave (
        input  value, load, digit_sel, blank_lead,
        output anode, segment, busy, done, overflow
    );
endinterface

// File: rtl/seg_display_driver.sv
// 4-digit common-anode 7-segment driver: sequential double-dabble binary-to-BCD
// conversion into held display registers, plus a registered one-cycle-latency scan stage.
module seg_display_driver #(
    parameter int VAL_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clock,
    input  logic                  reset,
    seg_display_driver_if.slave   bus
);

    localparam logic [VAL_W-1:0] MAX_VAL_V = VAL_W'(MAX_VAL);
    localparam logic [3:0]       LAST_ITER = 4'(VAL_W - 1);
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             capture_s;
    logic             shift_s;
    logic             commit_s;

    logic [VAL_W-1:0] bin_r;
    logic [15:0]      bcd_r;
    logic [15:0]      bcd_adj_s;
    logic [3:0]       iter_r;
    logic             ovf_pend_r;

    logic [3:0]       dig0_r;
    logic [3:0]       dig1_r;
    logic [3:0]       dig2_r;
    logic [3:0]       dig3_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;

    logic [3:0]       sel_digit_s;
    logic             blank_s;
    logic [3:0]       anode_r;
    logic [6:0]       segment_r;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a load is only taken from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (iter_r == LAST_ITER) begin
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode driving the datapath strobes.
    always_comb begin
        capture_s = 1'b0;
        shift_s   = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE:   capture_s = bus.load;
            ST_SHIFT:  shift_s   = 1'b1;
            ST_COMMIT: commit_s  = 1'b1;
            default: begin
                capture_s = 1'b0;
                shift_s   = 1'b0;
                commit_s  = 1'b0;
            end
        endcase
    end

    assign bcd_adj_s = dabble_adjust(bcd_r);

    // Conversion engine: capture, then one adjust-and-shift per SHIFT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_r      <= '0;
            bcd_r      <= 16'd0;
            iter_r     <= 4'd0;
            ovf_pend_r <= 1'b0;
        end else if (capture_s) begin
            bin_r      <= bus.value;
            bcd_r      <= 16'd0;
            iter_r     <= 4'd0;
            ovf_pend_r <= (bus.value > MAX_VAL_V);
        end else if (shift_s) begin
            bcd_r      <= {bcd_adj_s[14:0], bin_r[VAL_W-1]};
            bin_r      <= {bin_r[VAL_W-2:0], 1'b0};
            iter_r     <= iter_r + 4'd1;
        end else begin
            bin_r      <= bin_r;
            bcd_r      <= bcd_r;
            iter_r     <= iter_r;
            ovf_pend_r <= ovf_pend_r;
        end
    end

    // Display registers only change on COMMIT, so the scan never sees partial results.
    always_ff @(posedge clock) begin
        if (reset) begin
            dig0_r     <= 4'd0;
            dig1_r     <= 4'd0;
            dig2_r     <= 4'd0;
            dig3_r     <= 4'd0;
            overflow_r <= 1'b0;
        end else if (commit_s) begin
            dig0_r     <= bcd_r[3:0];
            dig1_r     <= bcd_r[7:4];
            dig2_r     <= bcd_r[11:8];
            dig3_r     <= bcd_r[15:12];
            overflow_r <= ovf_pend_r;
        end else begin
            dig0_r     <= dig0_r;
            dig1_r     <= dig1_r;
            dig2_r     <= dig2_r;
            dig3_r     <= dig3_r;
            overflow_r <= overflow_r;
        end
    end

    // Status flags; busy follows the upcoming state so it is high exactly while not IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= commit_s;
        end
    end

    // Scan multiplexer and leading-zero blanking for the selected digit.
    always_comb begin
        sel_digit_s = 4'd0;
        blank_s     = 1'b0;
        case (bus.digit_sel)
            2'd0: sel_digit_s = dig0_r;
            2'd1: sel_digit_s = dig1_r;
            2'd2: sel_digit_s = dig2_r;
            2'd3: sel_digit_s = dig3_r;
            default: sel_digit_s = 4'd0;
        endcase
        if (overflow_r || !bus.blank_lead) begin
            blank_s = 1'b0;
        end else begin
            case (bus.digit_sel)
                2'd0: blank_s = 1'b0;
                2'd1: blank_s = (dig1_r == 4'd0) && (dig2_r == 4'd0) && (dig3_r == 4'd0);
                2'd2: blank_s = (dig2_r == 4'd0) && (dig3_r == 4'd0);
                2'd3: blank_s = (dig3_r == 4'd0);
                default: blank_s = 1'b0;
            endcase
        end
    end

    // Registered output stage: one cycle behind digit_sel regardless of FSM state.
    always_ff @(posedge clock) begin
        if (reset) begin
            anode_r   <= 4'b1111;
            segment_r <= 7'b1111111;
        end else begin
            if (blank_s) begin
                anode_r <= 4'b1111;
            end else begin
                anode_r <= ~(4'b0001 << bus.digit_sel);
            end
            if (overflow_r) begin
                segment_r <= SEG_DASH;
            end else begin
                segment_r <= seg_encode(sel_digit_s);
            end
        end
    end

    assign bus.anode    = anode_r;
    assign bus.segment  = segment_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver: inputs change and outputs
// are sampled on the falling clock edge.
module tb_seg_display_driver;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    logic [3:0] an;
    logic [6:0] sg;
    logic [3:0] exp_an;
    logic [6:0] exp_sg;
    logic       exp_b;
    logic [6:0] exp_seg[4];
    logic [3:0] exp_ano[4];
    bit         ok;

    seg_display_driver_if bus ();

    seg_display_driver dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic read_digit(input logic [1:0] sel, output logic [3:0] a, output logic [6:0] s);
        bus.digit_sel = sel;
        @(negedge clock);
        a = bus.anode;
        s = bus.segment;
    endtask

    task automatic load_and_wait(input logic [13:0] v, output bit got_done);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        got_done  = 1'b0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            if (bus.done === 1'b1) got_done = 1'b1;
            else @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.digit_sel = 2'd0;
        repeat (3) @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.anode !== 4'b1111) begin failures++; $display("FAIL reset_anode: got %b expected 1111", bus.anode); end
        checks++; if (bus.segment !== 7'b1111111) begin failures++; $display("FAIL reset_segment: got %b expected 1111111", bus.segment); end
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            exp_an = ~(4'b0001 << i);
            checks++; if (bus.anode !== exp_an) begin failures++; $display("FAIL scan_anode[%0d]: got %b expected %b", i, bus.anode, exp_an); end
            checks++; if (bus.segment !== SEG_0) begin failures++; $display("FAIL scan_segment[%0d]: got %b expected %b", i, bus.segment, SEG_0); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL scan_busy[%0d]: got %b expected 0", i, bus.busy); end
            bus.digit_sel = 2'(i + 1);
            @(negedge clock);
        end
    endtask

    task automatic test_convert_1234();
        bus.blank_lead = 1'b0;
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        for (int e = 0; e <= 16; e++) begin
            exp_b = (e <= 14);
            checks++; if (bus.busy !== exp_b) begin failures++; $display("FAIL conv_busy@N+%0d: got %b expected %b", e, bus.busy, exp_b); end
            exp_b = (e == 15);
            checks++; if (bus.done !== exp_b) begin failures++; $display("FAIL conv_done@N+%0d: got %b expected %b", e, bus.done, exp_b); end
            @(negedge clock);
        end
        exp_seg[0] = SEG_4; exp_seg[1] = SEG_3; exp_seg[2] = SEG_2; exp_seg[3] = SEG_1;
        for (int i = 0; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            exp_an = ~(4'b0001 << i);
            checks++; if (sg !== exp_seg[i]) begin failures++; $display("FAIL d1234_segment[%0d]: got %b expected %b", i, sg, exp_seg[i]); end
            checks++; if (an !== exp_an) begin failures++; $display("FAIL d1234_anode[%0d]: got %b expected %b", i, an, exp_an); end
        end
    endtask

    task automatic test_blanking();
        load_and_wait(14'd7, ok);
        checks++; if (!ok) begin failures++; $display("FAIL blank7_done: got timeout expected done pulse"); end
        bus.blank_lead = 1'b1;
        exp_ano[0] = 4'b1110; exp_ano[1] = 4'b1111; exp_ano[2] = 4'b1111; exp_ano[3] = 4'b1111;
        read_digit(2'd0, an, sg);
        checks++; if (sg !== SEG_7) begin failures++; $display("FAIL blank7_seg0: got %b expected %b", sg, SEG_7); end
        for (int i = 0; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            checks++; if (an !== exp_ano[i]) begin failures++; $display("FAIL blank7_anode[%0d]: got %b expected %b", i, an, exp_ano[i]); end
        end
        bus.blank_lead = 1'b0;
        for (int i = 1; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            exp_an = ~(4'b0001 << i);
            checks++; if (sg !== SEG_0) begin failures++; $display("FAIL noblank7_seg[%0d]: got %b expected %b", i, sg, SEG_0); end
            checks++; if (an !== exp_an) begin failures++; $display("FAIL noblank7_anode[%0d]: got %b expected %b", i, an, exp_an); end
        end
        // 105: the inner zero stays lit because a nonzero digit sits above it
        load_and_wait(14'd105, ok);
        checks++; if (!ok) begin failures++; $display("FAIL blank105_done: got timeout expected done pulse"); end
        bus.blank_lead = 1'b1;
        exp_seg[0] = SEG_5; exp_seg[1] = SEG_0; exp_seg[2] = SEG_1; exp_seg[3] = SEG_0;
        exp_ano[0] = 4'b1110; exp_ano[1] = 4'b1101; exp_ano[2] = 4'b1011; exp_ano[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            checks++; if (an !== exp_ano[i]) begin failures++; $display("FAIL blank105_anode[%0d]: got %b expected %b", i, an, exp_ano[i]); end
            checks++; if (sg !== exp_seg[i]) begin failures++; $display("FAIL blank105_seg[%0d]: got %b expected %b", i, sg, exp_seg[i]); end
        end
        bus.blank_lead = 1'b0;
    endtask

    task automatic test_overflow();
        load_and_wait(14'd12000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_done: got timeout expected done pulse"); end
        @(negedge clock);
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag12000: got %b expected 1", bus.overflow); end
        bus.blank_lead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            exp_an = ~(4'b0001 << i);
            checks++; if (sg !== SEG_DASH) begin failures++; $display("FAIL ovf_seg[%0d]: got %b expected %b", i, sg, SEG_DASH); end
            checks++; if (an !== exp_an) begin failures++; $display("FAIL ovf_anode[%0d]: got %b expected %b", i, an, exp_an); end
        end
        load_and_wait(14'd9999, ok);
        checks++; if (!ok) begin failures++; $display("FAIL max_done: got timeout expected done pulse"); end
        @(negedge clock);
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag9999: got %b expected 0", bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            checks++; if (sg !== SEG_9) begin failures++; $display("FAIL max_seg[%0d]: got %b expected %b", i, sg, SEG_9); end
        end
        load_and_wait(14'd10000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf10000_done: got timeout expected done pulse"); end
        @(negedge clock);
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag10000: got %b expected 1", bus.overflow); end
        bus.blank_lead = 1'b0;
    endtask

    task automatic test_load_while_busy();
        bus.digit_sel = 2'd0;
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        bus.value = 14'd55;
        for (int e = 0; e <= 32; e++) begin
            exp_b = (e <= 14) || (e >= 16 && e <= 30);
            checks++; if (bus.busy !== exp_b) begin failures++; $display("FAIL lwb_busy@N+%0d: got %b expected %b", e, bus.busy, exp_b); end
            exp_b = (e == 15) || (e == 31);
            checks++; if (bus.done !== exp_b) begin failures++; $display("FAIL lwb_done@N+%0d: got %b expected %b", e, bus.done, exp_b); end
            if (e >= 16) begin
                exp_sg = (e <= 31) ? SEG_4 : SEG_5;
                checks++; if (bus.segment !== exp_sg) begin failures++; $display("FAIL lwb_seg0@N+%0d: got %b expected %b", e, bus.segment, exp_sg); end
            end
            bus.load = (e == 2) || (e == 14) || (e == 15);
            @(negedge clock);
        end
        bus.load = 1'b0;
        exp_seg[0] = SEG_5; exp_seg[1] = SEG_5; exp_seg[2] = SEG_0; exp_seg[3] = SEG_0;
        for (int i = 0; i < 4; i++) begin
            read_digit(2'(i), an, sg);
            checks++; if (sg !== exp_seg[i]) begin failures++; $display("FAIL d55_seg[%0d]: got %b expected %b", i, sg, exp_seg[i]); end
        end
    endtask

    task automatic test_reset_mid_conversion();
        bus.digit_sel  = 2'd1;
        bus.blank_lead = 1'b0;
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
        reset = 1'b0;
        bus.value = 14'd7;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        for (int e = 8; e <= 23; e++) begin
            exp_b = (e <= 22);
            checks++; if (bus.busy !== exp_b) begin failures++; $display("FAIL rst_reload_busy@N+%0d: got %b expected %b", e, bus.busy, exp_b); end
            exp_b = (e == 23);
            checks++; if (bus.done !== exp_b) begin failures++; $display("FAIL rst_reload_done@N+%0d: got %b expected %b", e, bus.done, exp_b); end
            if (e >= 9 && e <= 22) begin
                checks++; if (bus.segment !== SEG_0) begin failures++; $display("FAIL rst_cleared_seg1@N+%0d: got %b expected %b", e, bus.segment, SEG_0); end
                checks++; if (bus.anode !== 4'b1101) begin failures++; $display("FAIL rst_cleared_anode1@N+%0d: got %b expected 1101", e, bus.anode); end
            end
            @(negedge clock);
        end
        read_digit(2'd0, an, sg);
        checks++; if (sg !== SEG_7) begin failures++; $display("FAIL rst_reload_seg0: got %b expected %b", sg, SEG_7); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.value      = 14'd0;
        bus.load       = 1'b0;
        bus.digit_sel  = 2'd0;
        bus.blank_lead = 1'b0;
        test_reset();
        test_convert_1234();
        test_blanking();
        test_overflow();
        test_load_while_busy();
        test_reset_mid_conversion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
